// File: rtl/exm_pkg.sv
// Shared encodings for the ECAP5-DPROC execute stage: ALU ops, branch conditions,
// the branch-resolution helper and the control bundle forwarded to the load-store stage.
package exm_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'd0,
    ALU_XOR   = 3'd1,
    ALU_OR    = 3'd2,
    ALU_AND   = 3'd3,
    ALU_SLT   = 3'd4,
    ALU_SLTU  = 3'd5,
    ALU_SHIFT = 3'd6
  } alu_op_t;

  // JAL and JALR share one code; branch_jalr_i selects the target base.
  typedef enum logic [2:0] {
    BRANCH_NONE = 3'd0,
    BRANCH_BEQ  = 3'd1,
    BRANCH_BNE  = 3'd2,
    BRANCH_BLT  = 3'd3,
    BRANCH_BGE  = 3'd4,
    BRANCH_BLTU = 3'd5,
    BRANCH_BGEU = 3'd6,
    BRANCH_JAL  = 3'd7
  } branch_cond_t;

  typedef struct packed {
    logic            ls_enable;
    logic            ls_write;
    logic [XLEN-1:0] ls_write_data;
    logic [3:0]      ls_sel;
    logic            reg_write;
    logic [4:0]      reg_addr;
  } lsm_ctrl_t;

  function automatic logic branch_taken(
    input branch_cond_t    cond,
    input logic [XLEN-1:0] a,
    input logic [XLEN-1:0] b
  );
    logic taken;
    case (cond)
      BRANCH_BEQ:  taken = (a == b);
      BRANCH_BNE:  taken = (a != b);
      BRANCH_BLT:  taken = ($signed(a) <  $signed(b));
      BRANCH_BGE:  taken = ($signed(a) >= $signed(b));
      BRANCH_BLTU: taken = (a <  b);
      BRANCH_BGEU: taken = (a >= b);
      BRANCH_JAL:  taken = 1'b1;
      default:     taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/exm_if.sv
// Decode-to-execute and execute-to-lsm signal bundle; exm takes the slave view,
// the surrounding pipeline (decode, lsm, fetch redirect) takes the master view.
interface exm_if;
  import exm_pkg::*;

  logic               input_ready_o;
  logic               input_valid_i;
  logic [XLEN-1:0]    pc_i;
  logic [XLEN-1:0]    alu_operand1_i;
  logic [XLEN-1:0]    alu_operand2_i;
  alu_op_t            alu_op_i;
  logic               alu_sub_i;
  logic               alu_shift_left_i;
  logic               alu_signed_shift_i;
  branch_cond_t       branch_cond_i;
  logic               branch_jalr_i;
  logic [XLEN-1:0]    branch_offset_i;
  logic               ls_enable_i;
  logic               ls_write_i;
  logic [XLEN-1:0]    ls_write_data_i;
  logic [3:0]         ls_sel_i;
  logic               reg_write_i;
  logic [4:0]         reg_addr_i;

  logic               output_ready_i;
  logic               output_valid_o;
  logic [XLEN-1:0]    alu_result_o;
  logic               ls_enable_o;
  logic               ls_write_o;
  logic [XLEN-1:0]    ls_write_data_o;
  logic [3:0]         ls_sel_o;
  logic               reg_write_o;
  logic [4:0]         reg_addr_o;
  logic               branch_o;
  logic [XLEN-1:0]    branch_target_o;

  modport master (
    input  input_ready_o,
    output input_valid_i, pc_i, alu_operand1_i, alu_operand2_i, alu_op_i, alu_sub_i,
           alu_shift_left_i, alu_signed_shift_i, branch_cond_i, branch_jalr_i,
           branch_offset_i, ls_enable_i, ls_write_i, ls_write_data_i, ls_sel_i,
           reg_write_i, reg_addr_i,
    output output_ready_i,
    input  output_valid_o, alu_result_o, ls_enable_o, ls_write_o, ls_write_data_o,
           ls_sel_o, reg_write_o, reg_addr_o, branch_o, branch_target_o
  );

  modport slave (
    output input_ready_o,
    input  input_valid_i, pc_i, alu_operand1_i, alu_operand2_i, alu_op_i, alu_sub_i,
           alu_shift_left_i, alu_signed_shift_i, branch_cond_i, branch_jalr_i,
           branch_offset_i, ls_enable_i, ls_write_i, ls_write_data_i, ls_sel_i,
           reg_write_i, reg_addr_i,
    input  output_ready_i,
    output output_valid_o, alu_result_o, ls_enable_o, ls_write_o, ls_write_data_o,
           ls_sel_o, reg_write_o, reg_addr_o, branch_o, branch_target_o
  );

endinterface

// File: rtl/exm_alu.sv
// RV32I integer ALU: purely combinational, operands plus op controls to result.
module exm_alu
  import exm_pkg::*;
(
  input  logic [XLEN-1:0] operand1,
  input  logic [XLEN-1:0] operand2,
  input  alu_op_t         op,
  input  logic            sub,
  input  logic            shift_left,
  input  logic            signed_shift,
  output logic [XLEN-1:0] result
);

  logic [4:0]      shamt;
  logic [XLEN-1:0] sum;
  logic [XLEN-1:0] shifted;
  logic            less_signed;
  logic            less_unsigned;

  assign shamt         = operand2[4:0];
  assign sum           = sub ? (operand1 - operand2) : (operand1 + operand2);
  assign less_signed   = $signed(operand1) < $signed(operand2);
  assign less_unsigned = operand1 < operand2;

  always_comb begin
    shifted = operand1 >> shamt;
    if (shift_left) begin
      shifted = operand1 << shamt;
    end else if (signed_shift) begin
      shifted = $unsigned($signed(operand1) >>> shamt);
    end
  end

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:   result = sum;
      ALU_XOR:   result = operand1 ^ operand2;
      ALU_OR:    result = operand1 | operand2;
      ALU_AND:   result = operand1 & operand2;
      ALU_SLT:   result = {{(XLEN-1){1'b0}}, less_signed};
      ALU_SLTU:  result = {{(XLEN-1){1'b0}}, less_unsigned};
      ALU_SHIFT: result = shifted;
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/exm.sv
// ECAP5-DPROC execute stage: ALU, branch resolution and the registered hand-off to lsm.
module exm
  import exm_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  exm_if.slave bus
);

  logic            ready;
  logic            accept;
  logic            is_jump;
  logic            is_jalr;
  logic            taken;
  logic [XLEN-1:0] alu_result;
  logic [XLEN-1:0] target_base;
  logic [XLEN-1:0] target_sum;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] result;
  lsm_ctrl_t       in_ctrl;

  logic            out_valid;
  logic [XLEN-1:0] out_result;
  lsm_ctrl_t       out_ctrl;
  logic            out_branch;
  logic [XLEN-1:0] out_target;

  exm_alu u_alu (
    .operand1     (bus.alu_operand1_i),
    .operand2     (bus.alu_operand2_i),
    .op           (bus.alu_op_i),
    .sub          (bus.alu_sub_i),
    .shift_left   (bus.alu_shift_left_i),
    .signed_shift (bus.alu_signed_shift_i),
    .result       (alu_result)
  );

  assign ready  = !out_valid || bus.output_ready_i;
  assign accept = bus.input_valid_i && ready;

  assign is_jump = (bus.branch_cond_i == BRANCH_JAL);
  assign is_jalr = is_jump && bus.branch_jalr_i;
  assign taken   = branch_taken(bus.branch_cond_i, bus.alu_operand1_i, bus.alu_operand2_i);

  // JALR clears bit 0 of the computed address; every other target is pc-relative.
  assign target_base = is_jalr ? bus.alu_operand1_i : bus.pc_i;
  assign target_sum  = target_base + bus.branch_offset_i;
  assign target      = is_jalr ? {target_sum[XLEN-1:1], 1'b0} : target_sum;

  // Jumps write the link address to rd instead of the ALU output.
  assign result = is_jump ? (bus.pc_i + 32'd4) : alu_result;

  assign in_ctrl = '{
    ls_enable:     bus.ls_enable_i,
    ls_write:      bus.ls_write_i,
    ls_write_data: bus.ls_write_data_i,
    ls_sel:        bus.ls_sel_i,
    reg_write:     bus.reg_write_i,
    reg_addr:      bus.reg_addr_i
  };

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_ctrl   <= '0;
      out_branch <= 1'b0;
      out_target <= '0;
    end else begin
      // Redirect pulses on the accepting edge only, independent of downstream stalls.
      out_branch <= accept && taken;
      if (accept) begin
        out_valid  <= 1'b1;
        out_result <= result;
        out_ctrl   <= in_ctrl;
        if (taken) begin
          out_target <= target;
        end
      end else if (bus.output_ready_i) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign bus.input_ready_o   = ready;
  assign bus.output_valid_o  = out_valid;
  assign bus.alu_result_o    = out_result;
  assign bus.ls_enable_o     = out_ctrl.ls_enable;
  assign bus.ls_write_o      = out_ctrl.ls_write;
  assign bus.ls_write_data_o = out_ctrl.ls_write_data;
  assign bus.ls_sel_o        = out_ctrl.ls_sel;
  assign bus.reg_write_o     = out_ctrl.reg_write;
  assign bus.reg_addr_o      = out_ctrl.reg_addr;
  assign bus.branch_o        = out_branch;
  assign bus.branch_target_o = out_target;

endmodule

// File: doc/exm.md
Name: exm

Overview:
- Execute stage of the ECAP5-DPROC pipeline; sits between decode and the load-store module (lsm).
- Accepts decoded operands through a ready/valid handshake and computes the ALU result.
- Resolves branches and jumps, emitting a one-cycle redirect towards fetch/decode.
- Registers the result together with the load-store and register-write controls that lsm consumes.

Parameters:
- none. Widths are fixed at RV32I.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- input_ready_o  out  1  stage can accept an instruction this cycle
- input_valid_i  in  1  decode presents a valid instruction
- pc_i  in  32  PC of the presented instruction
- alu_operand1_i  in  32  first operand (rs1 or PC)
- alu_operand2_i  in  32  second operand (rs2 or immediate)
- alu_op_i  in  3  alu_op_t (ADD, XOR, OR, AND, SLT, SLTU, SHIFT)
- alu_sub_i  in  1  ADD performs subtraction
- alu_shift_left_i  in  1  SHIFT direction, 1 = left
- alu_signed_shift_i  in  1  right shift is arithmetic
- branch_cond_i  in  3  branch_cond_t (NONE, BEQ, BNE, BLT, BGE, BLTU, BGEU, JAL/JALR encoded with branch_jalr_i)
- branch_jalr_i  in  1  jump target base is operand1 instead of pc_i
- branch_offset_i  in  32  sign-extended branch/jump offset
- ls_enable_i  in  1  memory access
- ls_write_i  in  1  memory access is a store
- ls_write_data_i  in  32  store data
- ls_sel_i  in  4  byte select
- reg_write_i  in  1  instruction writes rd
- reg_addr_i  in  5  rd
- output_ready_i  in  1  lsm input_ready_o
- output_valid_o  out  1  registered outputs valid
- alu_result_o  out  32  result / memory address
- ls_enable_o  out  1  registered ls_enable_i
- ls_write_o  out  1  registered ls_write_i
- ls_write_data_o  out  32  registered ls_write_data_i
- ls_sel_o  out  4  registered ls_sel_i
- reg_write_o  out  1  registered reg_write_i
- reg_addr_o  out  5  registered reg_addr_i
- branch_o  out  1  taken branch/jump, one-cycle pulse
- branch_target_o  out  32  redirect address, valid while branch_o

Behaviour:
- Clock and reset: single clock domain on clk_i. rst_i is asynchronous and active-high.
- Reset values: all outputs 0 (output_valid_o, branch_o, data and control registers).
- Handshake:
  - input_ready_o = !output_valid_o || output_ready_i (combinational).
  - Accept occurs when input_valid_i && input_ready_o.
  - Latency is 1 cycle: results are registered on the accepting edge.
- Output valid: set on accept. Cleared when output_ready_i=1 and no accept in the same cycle.
  - On stall (output_valid_o=1, output_ready_i=0) every output register holds.
  - Accept and drain in the same cycle: new data replaces old, output_valid_o stays 1.
- ALU (all arithmetic mod 2^32):
  - ADD: op1+op2, or op1-op2 when alu_sub_i=1.
  - SLT: signed compare. SLTU: unsigned compare. Result is 0 or 1.
  - SHIFT: shift amount is op2[4:0]. Left shift, or right shift arithmetic/logical per alu_signed_shift_i.
- Jumps: for branch_cond=JAL, alu_result_o = pc_i+4, overriding the ALU.
- Branch targets:
  - JAL and conditional branches: pc_i+offset.
  - JAL with branch_jalr_i=1: (op1+offset) & ~1.
- Branch conditions compare op1 and op2:
  - BEQ/BNE: equality.
  - BLT/BGE: signed.
  - BLTU/BGEU: unsigned.
- branch_o: set for exactly one cycle after accepting a taken branch or any jump, even if the output is stalled. Cleared the next cycle.
  - branch_target_o holds its value until the next taken branch.
  - Upstream flushes on branch_o. This stage does not squash.
- Non-accept cycles: branch_o=0.
- Reset mid-stall: the held instruction is dropped and output_valid_o goes to 0 immediately.

Decomposition:
- ecap5_dproc_pkg: alu_op_t, branch_cond_t enums and ALU op encodings, shared with decode.
- One combinational sub-module, alu: operands plus op controls -> result. exm instantiates it and owns the registers and handshake.

Test Plan:
- Reset then idle -> output_valid_o=0, branch_o=0, input_ready_o=1.
- ADD 7 + (-3), reg_write_i=1, reg_addr_i=5, output_ready_i=1 -> next cycle output_valid_o=1, alu_result_o=4, reg_addr_o=5. SUB 3-7 -> 0xFFFFFFFC.
- SHIFT op1=0x80000000, op2=31:
  - arithmetic right -> 0xFFFFFFFF.
  - logical right -> 1.
  - left with op2=33 -> op1<<1.
- BLT pc=0x100, op1=-1, op2=1, offset=-16 -> branch_o pulse of 1 cycle, target 0xF0. BLTU with the same operands -> branch_o=0.
- JAL with branch_jalr_i=1, pc=0x200, op1=0x1003, offset=4 -> alu_result_o=0x204, branch_target_o=0x1006.
- Stall and reset:
  - output_ready_i=0 for 3 cycles with new input_valid_i -> input_ready_o=0, outputs held.
  - Release -> old instruction drains, new one is accepted the same cycle.
  - rst_i asserted mid-stall -> output_valid_o=0 asynchronously.
